// File: rtl/lm_sm_mem_sequencer_pkg.sv
// Shared definitions for the LM/SM memory-stage sequencer: FSM encoding and
// the architectural register count.
package lm_sm_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int unsigned MAX_REGS = 8;

endpackage

// File: rtl/lm_sm_mem_sequencer.sv
// Memory-stage sequencer for load-multiple / store-multiple: walks the register
// indices from the priority encoder, issuing one word access per register.
module lm_sm_mem_sequencer
  import lm_sm_mem_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [15:0] base_addr,
  input  logic        mask_empty,
  input  logic        reg_valid,
  input  logic [2:0]  reg_idx,
  input  logic        reg_last,
  output logic        reg_ready,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  rf_raddr,
  input  logic [15:0] rf_rdata,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        busy,
  output logic        done
);

  seq_state_e  state_q;
  logic        is_store_q;
  logic [15:0] addr_cnt_q;
  logic [3:0]  xfer_cnt_q;
  logic [3:0]  xfer_cnt_d;
  logic        rf_we_q;
  logic [2:0]  rf_waddr_q;
  logic [15:0] rf_wdata_q;

  logic        xfer_active;
  logic        handshake;
  logic        overflow;

  always_comb begin
    xfer_active = (state_q == ST_XFER);
    reg_ready   = xfer_active & mem_ready;
    handshake   = reg_valid & reg_ready;
    xfer_cnt_d  = xfer_cnt_q + 4'd1;
    // A handshake beyond MAX_REGS means the generator never flagged its last
    // register; force completion rather than run on indefinitely.
    overflow    = (xfer_cnt_q >= 4'(MAX_REGS));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      addr_cnt_q <= '0;
      xfer_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            addr_cnt_q <= base_addr;
            xfer_cnt_q <= '0;
            state_q    <= mask_empty ? ST_DONE : ST_XFER;
          end
        end
        ST_XFER: begin
          if (handshake) begin
            addr_cnt_q <= addr_cnt_q + 16'd1;
            xfer_cnt_q <= xfer_cnt_d;
            if (!is_store_q) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= reg_idx;
              rf_wdata_q <= mem_rdata;
            end
            if (reg_last || overflow) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_cnt_q;
  assign mem_re    = xfer_active & reg_valid & ~is_store_q;
  assign mem_we    = xfer_active & reg_valid & is_store_q;
  assign mem_wdata = rf_rdata;
  assign rf_raddr  = reg_idx;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: doc/lm_sm_mem_sequencer.md
LM_SM_MEM_SEQUENCER -- requirements
Module: lm_sm_mem_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  in  1  one-cycle pulse; LM/SM enters memory stage.
REQ-004 SHALL have port: is_store  in  1  1 = SM, 0 = LM; sampled with start.
REQ-005 SHALL have port: base_addr  in  16  base register value; sampled with start.
REQ-006 SHALL have port: mask_empty  in  1  register mask is all-zero; sampled with start.
REQ-007 SHALL have port: reg_valid  in  1  register-generator index valid (generator not stalled).
REQ-008 SHALL have port: reg_idx  in  3  register index from the priority encoder.
REQ-009 SHALL have port: reg_last  in  1  reg_idx is the final register of the mask.
REQ-010 SHALL have port: reg_ready  out  1  sequencer accepts reg_idx this cycle.
REQ-011 SHALL have port: mem_addr  out  16  memory word address.
REQ-012 SHALL have port: mem_re / mem_we  out  1 each  read / write strobe.
REQ-013 SHALL have port: mem_wdata  out  16  store data, equal to rf_rdata.
REQ-014 SHALL have port: mem_ready  in  1  memory completes the access this cycle.
REQ-015 SHALL have port: mem_rdata  in  16  load data, valid when mem_ready.
REQ-016 SHALL have port: rf_raddr  out  3  register-file read address (SM), equal to reg_idx.
REQ-017 SHALL have port: rf_rdata  in  16  register-file read data (combinational).
REQ-018 SHALL have port: rf_we, rf_waddr, rf_wdata  out  1/3/16  LM writeback.
REQ-019 SHALL have port: busy  out  1  high in XFER and DONE.
REQ-020 SHALL have port: done  out  1  one-cycle completion pulse.

Function
REQ-021 FSM SHALL have states IDLE, XFER, DONE.
- IDLE: start & !mask_empty -> XFER. start & mask_empty -> DONE.
- XFER: handshake on last register -> DONE.
- DONE -> IDLE unconditionally.
REQ-022 On start in IDLE, SHALL latch is_store and load addr_cnt = base_addr.
REQ-023 In XFER: mem_addr = addr_cnt; mem_re = reg_valid & !is_store; mem_we = reg_valid & is_store. Both strobes SHALL be 0 outside XFER.
REQ-024 reg_ready SHALL equal (state==XFER) & mem_ready; handshake = reg_valid & reg_ready.
REQ-025 Each handshake SHALL increment addr_cnt by 1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-026 LM writeback SHALL have latency 1.
- The cycle after a load handshake: rf_we=1, rf_waddr = that reg_idx, rf_wdata = that mem_rdata.
- rf_we SHALL be 0 otherwise, and never for SM.
REQ-027 A 4-bit xfer_cnt SHALL count handshakes. A handshake that would make it exceed 8 SHALL still forward to DONE (protocol-error guard).
REQ-028 done SHALL be 1 exactly in the DONE cycle.
REQ-029 start while busy SHALL be ignored; reg_valid in IDLE/DONE SHALL be ignored.
REQ-030 Simultaneous reg_valid=0 and mem_ready=1 in XFER SHALL perform no transfer and leave addr_cnt unchanged.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE, addr_cnt=0, xfer_cnt=0, rf_we=0, done=0, and all strobes 0; this includes mid-XFER, with no pending writeback issued.
REQ-032 Outputs SHALL hold reset values from the first edge with rst=0 until the first edge with rst=1.

Structure
REQ-033 FSM state encoding and the constant MAX_REGS=8 SHALL live in the shared processor package.
REQ-034 Single module, no sub-modules; the address counter SHALL be inline.

Verification
REQ-035 LM, base=0x0100, indices 1,3,7 (last on 7), mem_ready=1 -> reads at 0x0100/0x0101/0x0102; rf writes R1,R3,R7 one cycle later each; done 1 cycle after the third handshake.
REQ-036 SM, base=0xFFFF, indices 0,2 -> mem_we at 0xFFFF then 0x0000; mem_wdata = rf_rdata of R0, R2; rf_we never 1.
REQ-037 mask_empty=1 with start -> no strobes; done on the next cycle; then IDLE.
REQ-038 LM with mem_ready low 3 cycles on the 2nd access -> mem_addr holds, reg_ready=0, no extra rf_we; completes correctly once mem_ready rises.
REQ-039 rst=0 during XFER after 2 of 4 transfers -> next cycle IDLE, no rf_we, no done; a new start at base 0x0020 runs cleanly.
REQ-040 start pulsed while busy -> ignored; addr sequence and done timing unchanged.
